// File: rtl/qspi_psram_pkg.sv
// Shared constants and types for the QSPI PSRAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: quad command opcodes, controller state enum, SPI-cycle counter width.
package qspi_psram_pkg;

  localparam logic [7:0] CMD_QREAD  = 8'h0B;
  localparam logic [7:0] CMD_QWRITE = 8'h02;

  // Wide enough for address nibbles, dummy cycles, up to 8 data nibbles and the CS guard.
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    RDATA,
    WDATA,
    GUARD
  } state_t;

endpackage

// File: rtl/qspi_nibble_shifter.sv
// 32-bit nibble shifter: emits cmd/addr/wdata MSB-nibble first, assembles read nibbles.
// Latency: nib_out is registered; rd_asm_nxt shows the assembly including this cycle's capture.
// Backpressure: none; the controller drives load/shift/cap once per SPI cycle.
// Ports: clk/rst; load+load_val, shift, clr (clear read assembly); cap+cap_nib+cap_idx
//        (read nibble index, high nibble first per byte, byte0 first); nib_out, rd_asm_nxt.
module qspi_nibble_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift,
  input  logic        clr,
  input  logic        cap,
  input  logic [3:0]  cap_nib,
  input  logic [2:0]  cap_idx,
  output logic [3:0]  nib_out,
  output logic [31:0] rd_asm_nxt
);

  logic [31:0] sr;
  logic [31:0] rd_asm;
  logic [4:0]  cap_pos;

  // Nibble k belongs to byte k/2; even k is the high nibble of that byte.
  always_comb begin
    cap_pos    = {cap_idx[2:1], ~cap_idx[0], 2'b00};
    rd_asm_nxt = rd_asm;
    if (cap) rd_asm_nxt[cap_pos +: 4] = cap_nib;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr     <= '0;
      rd_asm <= '0;
    end else begin
      if (load)       sr <= load_val;
      else if (shift) sr <= {sr[27:0], 4'h0};
      if (clr) rd_asm <= '0;
      else     rd_asm <= rd_asm_nxt;
    end
  end

  assign nib_out = sr[31:28];

endmodule

// File: rtl/qspi_psram_ctrl.sv
// Two-port (fetch/data) quad-SPI PSRAM controller; spi_clk = clk/2, quad read 0x0B / write 0x02.
// Latency: cs_n low 2*(2+ADDR_W/4+DUMMY_CYCLES+2N) clk for reads, 2*(2+ADDR_W/4+2N) for writes; response in first guard cycle.
// Backpressure: combinational readies, high only in IDLE after the CS guard; one ready at a time.
// Ports: clk/rst; f_req_* / f_rdata / f_rvalid fetch port; d_req_* / d_wdata / d_rdata / d_rvalid / d_wdone
//        data port; spi_clk, spi_cs_n, spi_data_out/oe/in to the PSRAM.
// Option: define QSPI_RR_ARB_EN for round-robin arbitration; default is data-over-fetch priority.
module qspi_psram_ctrl
  import qspi_psram_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int DUMMY_CYCLES   = 4,
  parameter int CS_HIGH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_valid,
  input  logic [ADDR_W-1:0] f_req_addr,
  output logic              f_req_ready,
  output logic [31:0]       f_rdata,
  output logic              f_rvalid,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [1:0]        d_req_len,
  input  logic [31:0]       d_wdata,
  output logic              d_req_ready,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic              d_wdone,
  output logic              spi_clk,
  output logic              spi_cs_n,
  output logic [3:0]        spi_data_out,
  output logic [3:0]        spi_data_oe,
  input  logic [3:0]        spi_data_in
);

  localparam int ADDR_NIB = ADDR_W / 4;

  state_t             state;
  logic               phase;     // 0 = spi_clk low half, 1 = high half
  logic [CNT_W-1:0]   cnt;       // SPI cycles left in phase, or guard clks left
  logic               is_wr;
  logic               is_data;
  logic [1:0]         len;
  logic [31:0]        wdata_q;

  logic               idle_ok, d_prio, d_sel, acc_d, acc_f, accept;
  logic               cyc_end, addr_last;
  logic [ADDR_W-1:0]  req_addr;
  logic [23:0]        addr24;
  logic [7:0]         cmd_sel;
  logic [31:0]        wswap, sh_val, rd_nxt;
  logic               sh_load;
  logic [2:0]         last_idx, cap_idx;

`ifdef QSPI_RR_ARB_EN
  logic               last_data;
  assign d_prio = !last_data;
`else
  assign d_prio = 1'b1;
`endif

  // Arbitration: ready depends on valid so an idle high-priority port never blocks the other.
  assign idle_ok     = !rst && (state == IDLE);
  assign d_sel       = d_req_valid && (!f_req_valid || d_prio);
  assign d_req_ready = idle_ok && d_sel;
  assign f_req_ready = idle_ok && f_req_valid && !d_sel;
  assign acc_d       = d_req_valid && d_req_ready;
  assign acc_f       = f_req_valid && f_req_ready;
  assign accept      = acc_d || acc_f;

  assign req_addr  = acc_d ? d_req_addr : f_req_addr;
  assign addr24    = 24'(req_addr) << (24 - ADDR_W);
  assign cmd_sel   = (acc_d && d_req_we) ? CMD_QWRITE : CMD_QREAD;
  // Byte0 goes out first, each byte high nibble first.
  assign wswap     = {wdata_q[7:0], wdata_q[15:8], wdata_q[23:16], wdata_q[31:24]};

  // phase is only ever 1 in the bus-active states, so it marks the end of an SPI cycle.
  assign cyc_end   = phase;
  assign addr_last = (state == ADDR) && (cnt == '0);
  assign last_idx  = {len, 1'b1};
  assign cap_idx   = last_idx - cnt[2:0];
  assign sh_load   = accept || (cyc_end && addr_last && is_wr);
  assign sh_val    = accept ? {cmd_sel, addr24} : wswap;

  qspi_nibble_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (sh_load),
    .load_val   (sh_val),
    .shift      (cyc_end),
    .clr        (accept),
    .cap        (cyc_end && (state == RDATA)),
    .cap_nib    (spi_data_in),
    .cap_idx    (cap_idx),
    .nib_out    (spi_data_out),
    .rd_asm_nxt (rd_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 1'b0;
      cnt         <= '0;
      is_wr       <= 1'b0;
      is_data     <= 1'b0;
      len         <= '0;
      wdata_q     <= '0;
      spi_clk     <= 1'b0;
      spi_cs_n    <= 1'b1;
      spi_data_oe <= 4'h0;
      f_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
      d_wdone     <= 1'b0;
      f_rdata     <= '0;
      d_rdata     <= '0;
`ifdef QSPI_RR_ARB_EN
      last_data   <= 1'b1;
`endif
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_wdone  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= CMD;
            phase       <= 1'b0;
            cnt         <= CNT_W'(1);
            spi_cs_n    <= 1'b0;
            spi_data_oe <= 4'hF;
            is_data     <= acc_d;
            is_wr       <= acc_d && d_req_we;
            len         <= acc_d ? d_req_len : 2'd3;
            if (acc_d) wdata_q <= d_wdata;
`ifdef QSPI_RR_ARB_EN
            last_data   <= acc_d;
`endif
          end
        end
        GUARD: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          if (!phase) begin
            spi_clk <= 1'b1;
            phase   <= 1'b1;
          end else begin
            spi_clk <= 1'b0;
            phase   <= 1'b0;
            cnt     <= cnt - 1'b1;
            if (cnt == '0) begin
              case (state)
                CMD: begin
                  state <= ADDR;
                  cnt   <= CNT_W'(ADDR_NIB - 1);
                end
                ADDR: begin
                  if (is_wr) begin
                    state <= WDATA;
                    cnt   <= CNT_W'(last_idx);
                  end else begin
                    state       <= DUMMY;
                    spi_data_oe <= 4'h0;
                    cnt         <= CNT_W'(DUMMY_CYCLES - 1);
                  end
                end
                DUMMY: begin
                  state <= RDATA;
                  cnt   <= CNT_W'(last_idx);
                end
                default: begin
                  // End of RDATA/WDATA: release the bus and respond in the first guard cycle.
                  state       <= GUARD;
                  cnt         <= CNT_W'(CS_HIGH_CYCLES - 1);
                  spi_cs_n    <= 1'b1;
                  spi_data_oe <= 4'h0;
                  if (is_wr) begin
                    d_wdone <= 1'b1;
                  end else if (is_data) begin
                    d_rvalid <= 1'b1;
                    d_rdata  <= rd_nxt;
                  end else begin
                    f_rvalid <= 1'b1;
                    f_rdata  <= rd_nxt;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Self-checking bench for qspi_psram_ctrl with a behavioural quad-SPI PSRAM model.
// Read responses are checked through an expectation queue; timing and bus content are checked directly.
module tb_qspi_psram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req_valid = 1'b0;
  logic [23:0] f_req_addr = '0;
  logic        f_req_ready;
  logic [31:0] f_rdata;
  logic        f_rvalid;
  logic        d_req_valid = 1'b0;
  logic        d_req_we = 1'b0;
  logic [23:0] d_req_addr = '0;
  logic [1:0]  d_req_len = '0;
  logic [31:0] d_wdata = '0;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_wdone;
  logic        spi_clk;
  logic        spi_cs_n;
  logic [3:0]  spi_data_out;
  logic [3:0]  spi_data_oe;
  logic [3:0]  spi_data_in = 4'h0;

  qspi_psram_ctrl #(.ADDR_W(24), .DUMMY_CYCLES(4), .CS_HIGH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_rdata(f_rdata), .f_rvalid(f_rvalid),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_len(d_req_len), .d_wdata(d_wdata), .d_req_ready(d_req_ready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_wdone(d_wdone),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_data_out(spi_data_out),
    .spi_data_oe(spi_data_oe), .spi_data_in(spi_data_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- PSRAM model ----------------
  logic [7:0]  mem [int];
  int          ncnt = 0;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  logic [63:0] m_nibs = '0;
  int          m_nnib = 0;
  int          dummy_oe_bad = 0;
  logic [3:0]  m_whi = '0;

  always @(negedge spi_cs_n) begin
    ncnt = 0; m_nnib = 0; m_nibs = '0; dummy_oe_bad = 0;
  end

  always @(posedge spi_clk) begin
    int k, a;
    logic [7:0] b;
    if (!spi_cs_n) begin
      if (ncnt < 2)      m_cmd  = {m_cmd[3:0], spi_data_out};
      else if (ncnt < 8) m_addr = {m_addr[19:0], spi_data_out};
      if (spi_data_oe == 4'hF) begin
        m_nibs = {m_nibs[59:0], spi_data_out};
        m_nnib++;
      end
      if (m_cmd == 8'h0B && ncnt >= 8 && ncnt < 12 && spi_data_oe != 4'h0) dummy_oe_bad++;
      if (m_cmd == 8'h02 && ncnt >= 8) begin
        k = ncnt - 8;
        a = int'(m_addr) + k / 2;
        if (k % 2 == 0) m_whi = spi_data_out;
        else            mem[a] = {m_whi, spi_data_out};
      end
      if (m_cmd == 8'h0B && ncnt >= 12) begin
        k = ncnt - 12;
        a = int'(m_addr) + k / 2;
        b = mem.exists(a) ? mem[a] : 8'hFF;
        spi_data_in = (k % 2 == 0) ? b[7:4] : b[3:0];
      end
      ncnt++;
    end
  end

  // ---------------- bus timing monitor ----------------
  int lo_run = 0, last_low = 0, hi_run = 99, min_high = 1000, guard_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      lo_run = 0; hi_run = 99;
    end else if (!spi_cs_n) begin
      if (lo_run == 0 && hi_run < min_high) min_high = hi_run;
      lo_run++; hi_run = 0;
    end else begin
      if (lo_run > 0) begin last_low = lo_run; lo_run = 0; end
      hi_run++;
      if ((d_req_ready || f_req_ready) && hi_run <= 2) guard_viol++;
    end
  end

  // ---------------- response scoreboard ----------------
  typedef struct packed { logic is_d; logic [31:0] dat; } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  task automatic push_exp(input logic is_d, input logic [31:0] dat);
    exp_t e;
    e.is_d = is_d; e.dat = dat;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (d_rvalid || f_rvalid)) begin
      chk("sb_expected_rsp", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        chk("sb_port", {d_rvalid, f_rvalid}, sb_e.is_d ? 2'b10 : 2'b01);
        chk("sb_data", d_rvalid ? d_rdata : f_rdata, sb_e.dat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic req_d(input logic we, input logic [23:0] a, input logic [1:0] len, input logic [31:0] wd);
    d_req_valid = 1'b1; d_req_we = we; d_req_addr = a; d_req_len = len; d_wdata = wd;
    #1;
    for (int i = 0; i < 300 && !d_req_ready; i++) tick();
    chk("d_accept", d_req_ready, 1'b1);
    tick();
    d_req_valid = 1'b0;
  endtask

  task automatic req_f(input logic [23:0] a);
    f_req_valid = 1'b1; f_req_addr = a;
    #1;
    for (int i = 0; i < 300 && !f_req_ready; i++) tick();
    chk("f_accept", f_req_ready, 1'b1);
    tick();
    f_req_valid = 1'b0;
  endtask

  // which: 0 = f_rvalid, 1 = d_rvalid, 2 = d_wdone
  task automatic wait_rsp(input int which, output int lat);
    bit seen;
    seen = 0; lat = 0;
    for (int i = 0; i < 300; i++) begin
      tick(); lat++;
      if ((which == 0 && f_rvalid) || (which == 1 && d_rvalid) || (which == 2 && d_wdone)) begin
        seen = 1; break;
      end
    end
    chk("rsp_seen", seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, gap, pulses;
    bit exp_d, last_d;

    // Reset values, with both requests pending to show readies are gated.
    d_req_valid = 1'b1; f_req_valid = 1'b1; rst = 1'b1;
    repeat (3) tick();
    chk("rst_spi_clk", spi_clk, 1'b0);
    chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_oe", spi_data_oe, 4'h0);
    chk("rst_data_out", spi_data_out, 4'h0);
    chk("rst_readies", {d_req_ready, f_req_ready}, 2'b00);
    chk("rst_pulses", {f_rvalid, d_rvalid, d_wdone}, 3'b000);
    chk("rst_rdata", {f_rdata, d_rdata}, 64'h0);
    d_req_valid = 1'b0; f_req_valid = 1'b0; rst = 1'b0;
    repeat (2) tick();

    // Full-word write.
    req_d(1'b1, 24'h000010, 2'd3, 32'hDDCCBBAA);
    wait_rsp(2, lat);
    chk("wr_wdone_latency", lat, 32);
    settle();
    chk("wr_cs_low", last_low, 32);
    chk("wr_bus_nibbles", m_nibs, 64'h02000010AABBCCDD);
    chk("wr_nibble_count", m_nnib, 16);

    // Fetch the written word back.
    push_exp(1'b0, 32'hDDCCBBAA);
    req_f(24'h000010);
    wait_rsp(0, lat);
    chk("fetch_latency", lat, 40);
    settle();
    chk("fetch_cmd", m_cmd, 8'h0B);
    chk("fetch_dummy_oe", dummy_oe_bad, 0);
    chk("fetch_driven_nibbles", m_nnib, 8);
    chk("fetch_cs_low", last_low, 40);
    tick();
    chk("fetch_rvalid_single", f_rvalid, 1'b0);
    repeat (3) tick();
    chk("fetch_rdata_hold", f_rdata, 32'hDDCCBBAA);

    // Single-byte read of unwritten memory.
    push_exp(1'b1, 32'h000000FF);
    req_d(1'b0, 24'h000100, 2'd0, 32'h0);
    wait_rsp(1, lat);
    settle();
    chk("rd1_cs_low", last_low, 28);
    chk("rd1_rdata", d_rdata, 32'h000000FF);
    last_d = 1'b1;

    // Contention, twice.
    for (int r = 0; r < 2; r++) begin
`ifdef QSPI_RR_ARB_EN
      exp_d = !last_d;
`else
      exp_d = 1'b1;
`endif
      repeat (4) tick();
      d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 24'h000010; d_req_len = 2'd1;
      f_req_valid = 1'b1; f_req_addr = 24'h000100;
      #1;
      chk("arb_d_ready", d_req_ready, exp_d);
      chk("arb_f_ready", f_req_ready, !exp_d);
      if (exp_d) begin
        push_exp(1'b1, 32'h0000BBAA); push_exp(1'b0, 32'hFFFFFFFF);
      end else begin
        push_exp(1'b0, 32'hFFFFFFFF); push_exp(1'b1, 32'h0000BBAA);
      end
      tick();
      if (exp_d) d_req_valid = 1'b0; else f_req_valid = 1'b0;
      gap = -1;
      for (int i = 0; i < 300; i++) begin
        if (exp_d ? d_rvalid : f_rvalid) gap = 0;
        else if (gap >= 0) gap++;
        if (exp_d ? f_req_ready : d_req_ready) break;
        tick();
      end
      chk("arb_loser_wait", gap, 2);
      tick();
      if (exp_d) f_req_valid = 1'b0; else d_req_valid = 1'b0;
      wait_rsp(exp_d ? 0 : 1, lat);
      last_d = !exp_d;
    end

    // Reset in the middle of the read-data phase.
    repeat (4) tick();
    req_f(24'h000010);
    repeat (27) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_cs_n", spi_cs_n, 1'b1);
    chk("rst_mid_oe", spi_data_oe, 4'h0);
    chk("rst_mid_spi_clk", spi_clk, 1'b0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      if (f_rvalid || d_rvalid) pulses++;
      tick();
    end
    chk("rst_mid_no_rvalid", pulses, 0);
    push_exp(1'b0, 32'hDDCCBBAA);
    req_f(24'h000010);
    wait_rsp(0, lat);
    settle();
    chk("post_rst_cs_low", last_low, 40);

    // Back-to-back requests.
    req_d(1'b1, 24'h000200, 2'd1, 32'h00005678);
    push_exp(1'b1, 32'h00005678);
    req_d(1'b0, 24'h000200, 2'd1, 32'h0);
    push_exp(1'b0, 32'hFFFF5678);
    req_f(24'h000200);
    wait_rsp(0, lat);
    settle();
    chk("b2b_min_cs_high", min_high >= 2, 1'b1);
    chk("b2b_ready_in_guard", guard_viol, 0);

    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
